// File: rtl/occg_read_arbiter.sv
// Round-robin read arbiter sharing the dual-read-port OCCG occurrence-table SRAM
// between NUM_REQ backward-search engines, plus the table-load write sequencer.
module occg_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DEPTH      = 18,
    parameter int WIDTHS     = 1920,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    // search-engine read requests
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr0,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr1,
    output logic [NUM_REQ-1:0]            req_grant,
    // responses (data is broadcast, resp_valid selects the engine)
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic                          resp_err,
    output logic [WIDTHS-1:0]             resp_data0,
    output logic [WIDTHS-1:0]             resp_data1,
    // table load
    input  logic                          ld_valid,
    input  logic                          ld_last,
    input  logic [ADDR_WIDTH-1:0]         ld_addr,
    input  logic [WIDTHS-1:0]             ld_data,
    output logic                          ld_ready,
    output logic                          ld_err,
    output logic                          run,
    // SRAM ports
    output logic                          sram_wEn,
    output logic [ADDR_WIDTH-1:0]         sram_wAddr,
    output logic [WIDTHS-1:0]             sram_wData,
    output logic                          sram_rEn,
    output logic [ADDR_WIDTH-1:0]         sram_rAddr0,
    output logic [ADDR_WIDTH-1:0]         sram_rAddr1,
    input  logic [WIDTHS-1:0]             sram_rData0,
    input  logic [WIDTHS-1:0]             sram_rData1
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     w_next_ptr;
    logic [NUM_REQ-1:0]   r_resp_valid;
    logic                 r_resp_err;
    logic                 r_ld_err;

    logic                 w_arb_en;
    logic                 w_found;
    logic [PTR_W-1:0]     w_grant_idx;
    logic [NUM_REQ-1:0]   w_grant;
    logic [ADDR_WIDTH-1:0] w_sel_addr0;
    logic [ADDR_WIDTH-1:0] w_sel_addr1;
    logic                 w_addr_ok;
    logic                 w_ld_in_range;

    // Unsigned compare on the full address width; a zero-extended operand keeps
    // DEPTH == 2**ADDR_WIDTH from wrapping to zero.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, addr} < DEPTH_LIM;
    endfunction

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return PTR_W'(sum);
    endfunction

    // ---------------------------------------------------------------- write path
    assign w_ld_in_range = in_range(ld_addr);
    assign sram_wEn      = ld_valid & w_ld_in_range;
    assign sram_wAddr    = ld_addr;
    assign sram_wData    = ld_data;
    assign ld_ready      = 1'b1;

    // ---------------------------------------------------------------- arbitration
    // A pending load blocks all reads this cycle so a row is never read while it changes.
    assign w_arb_en = (r_state == ST_RUN) & ~ld_valid & ~rst;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        w_found     = 1'b0;
        w_grant_idx = '0;
        if (w_arb_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!w_found && req_valid[wrap_idx(r_rr_ptr, k)]) begin
                    w_found     = 1'b1;
                    w_grant_idx = wrap_idx(r_rr_ptr, k);
                end
            end
        end
    end

    assign w_grant   = w_found ? (NUM_REQ'(1) << w_grant_idx) : '0;
    assign req_grant = w_grant;

    assign w_next_ptr = !w_found                           ? r_rr_ptr :
                        (w_grant_idx == PTR_W'(NUM_REQ-1)) ? '0       :
                                                             w_grant_idx + PTR_W'(1);

    // ---------------------------------------------------------------- read issue
    assign w_sel_addr0 = req_addr0[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_addr1 = req_addr1[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_addr_ok   = in_range(w_sel_addr0) & in_range(w_sel_addr1);

    assign sram_rEn    = w_found & w_addr_ok;
    assign sram_rAddr0 = w_sel_addr0;
    assign sram_rAddr1 = w_sel_addr1;

    // ---------------------------------------------------------------- state machine
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT: if (ld_valid && ld_last) w_next_state = ST_RUN;
            ST_RUN:  w_next_state = ST_RUN;
            default: w_next_state = ST_INIT;
        endcase
    end

    assign run = (r_state == ST_RUN);

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_rr_ptr     <= '0;
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            r_ld_err     <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_rr_ptr     <= w_next_ptr;
            r_resp_valid <= w_grant;
            r_resp_err   <= w_found & ~w_addr_ok;
            r_ld_err     <= ld_valid & ~w_ld_in_range;
        end
    end

    // ---------------------------------------------------------------- response
    // The response already registered when rst arrives is suppressed, so a reset
    // discards the in-flight read in the same cycle it is asserted.
    assign resp_valid = rst ? '0 : r_resp_valid;
    assign resp_err   = ~rst & r_resp_err;
    assign resp_data0 = sram_rData0;
    assign resp_data1 = sram_rData1;
    assign ld_err     = r_ld_err;

endmodule

// File: tb/tb_occg_read_arbiter.sv
// Self-checking bench for occg_read_arbiter: behavioural SRAM, a per-cycle
// reference model of arbitration/response rules, and directed scenarios T1..T5.
module tb_occg_read_arbiter;

    localparam int N  = 4;
    localparam int D  = 18;
    localparam int W  = 1920;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr0, req_addr1;
    logic [N-1:0]    req_grant, resp_valid;
    logic            resp_err;
    logic [W-1:0]    resp_data0, resp_data1;
    logic            ld_valid, ld_last, ld_ready, ld_err, run;
    logic [AW-1:0]   ld_addr;
    logic [W-1:0]    ld_data;
    logic            sram_wEn, sram_rEn;
    logic [AW-1:0]   sram_wAddr, sram_rAddr0, sram_rAddr1;
    logic [W-1:0]    sram_wData, sram_rData0, sram_rData1;

    always #5 clk = ~clk;

    occg_read_arbiter #(.NUM_REQ(N), .DEPTH(D), .WIDTHS(W), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_grant(req_grant), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_data0(resp_data0), .resp_data1(resp_data1),
        .ld_valid(ld_valid), .ld_last(ld_last), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_err(ld_err), .run(run),
        .sram_wEn(sram_wEn), .sram_wAddr(sram_wAddr), .sram_wData(sram_wData),
        .sram_rEn(sram_rEn), .sram_rAddr0(sram_rAddr0), .sram_rAddr1(sram_rAddr1),
        .sram_rData0(sram_rData0), .sram_rData1(sram_rData1)
    );

    // Behavioural SRAM: synchronous write, registered read.
    logic [W-1:0] sram_mem [D];
    always @(posedge clk) begin
        if (sram_wEn) sram_mem[sram_wAddr] <= sram_wData;
        if (sram_rEn) begin
            sram_rData0 <= sram_mem[sram_rAddr0];
            sram_rData1 <= sram_mem[sram_rAddr1];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_row(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: row data differs, got low word %08h expected low word %08h at t=%0t",
                     name, act[31:0], exp[31:0], $time);
        end
    endtask

    function automatic logic [W-1:0] row_val(input int unsigned r, input int unsigned salt);
        logic [W-1:0] v;
        for (int j = 0; j < W/32; j++)
            v[j*32 +: 32] = 32'((r * 32'h0100_0193) ^ (salt * 32'h9e37_79b9) ^
                                (int'(j) * 32'h0001_0001) ^ 32'h5a5a_5a5a);
        return v;
    endfunction

    task automatic set_addr(input int eng, input int a0, input int a1);
        req_addr0[eng*AW +: AW] = AW'(a0);
        req_addr1[eng*AW +: AW] = AW'(a1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // ------------------------------------------------------------ reference model
    bit           chk_en = 1'b0;
    bit           m_run = 1'b0;
    int           m_ptr = 0;
    int           m_pend = -1;
    bit           m_pend_err = 1'b0;
    bit           m_ld_err = 1'b0;
    logic [W-1:0] m_pd0, m_pd1;
    logic [W-1:0] m_mem [D];
    int           e_g, e_a0, e_a1;
    bit           e_ok;
    logic [N-1:0] e_grant, e_resp;

    always @(negedge clk) begin
        if (chk_en) begin
            e_g = -1;
            if (!rst && m_run && !ld_valid)
                for (int k = 0; k < N; k++)
                    if (e_g < 0 && req_valid[(m_ptr + k) % N]) e_g = (m_ptr + k) % N;
            e_grant = (e_g >= 0) ? N'(1 << e_g) : '0;
            e_a0 = (e_g >= 0) ? int'(req_addr0[e_g*AW +: AW]) : 0;
            e_a1 = (e_g >= 0) ? int'(req_addr1[e_g*AW +: AW]) : 0;
            e_ok = (e_a0 < D) && (e_a1 < D);
            e_resp = (!rst && m_pend >= 0) ? N'(1 << m_pend) : '0;

            check("m_grant", req_grant, e_grant);
            check("m_rEn", sram_rEn, (e_g >= 0) && e_ok);
            if (e_g >= 0 && e_ok) begin
                check("m_rAddr0", sram_rAddr0, e_a0);
                check("m_rAddr1", sram_rAddr1, e_a1);
            end
            check("m_wEn", sram_wEn, ld_valid && (ld_addr < D));
            if (ld_valid) check("m_wAddr", sram_wAddr, ld_addr);
            check("m_ld_ready", ld_ready, 1);
            check("m_run", run, m_run);
            check("m_ld_err", ld_err, m_ld_err);
            check("m_resp_valid", resp_valid, e_resp);
            check("m_resp_err", resp_err, !rst && m_pend >= 0 && m_pend_err);
            if (!rst && m_pend >= 0 && !m_pend_err) begin
                check_row("m_resp_data0", resp_data0, m_pd0);
                check_row("m_resp_data1", resp_data1, m_pd1);
            end

            // advance to the next cycle; reads see the table before this cycle's write
            if (e_g >= 0 && e_ok) begin
                m_pd0 = m_mem[e_a0];
                m_pd1 = m_mem[e_a1];
            end
            if (ld_valid && ld_addr < D) m_mem[ld_addr] = ld_data;
            if (rst) begin
                m_run = 1'b0; m_ptr = 0; m_pend = -1; m_pend_err = 1'b0; m_ld_err = 1'b0;
            end else begin
                m_ld_err   = ld_valid && (ld_addr >= D);
                m_pend     = e_g;
                m_pend_err = !e_ok;
                if (e_g >= 0) m_ptr = (e_g + 1) % N;
                if (ld_valid && ld_last) m_run = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ directed stimulus
    logic [N-1:0] exp_t1 [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        rst = 1'b1; req_valid = '0; req_addr0 = '0; req_addr1 = '0;
        ld_valid = 1'b0; ld_last = 1'b0; ld_addr = '0; ld_data = '0;
        step();
        chk_en = 1'b1;
        sample();
        check("rst_run", run, 0);
        check("rst_grant", req_grant, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_ld_err", ld_err, 0);
        check("rst_ld_ready", ld_ready, 1);

        // T1: load the table with all engines requesting; nothing may be granted in INIT
        step();
        rst = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) set_addr(i, i, 17 - i);
        for (int r = 0; r < D; r++) begin
            ld_valid = 1'b1; ld_addr = AW'(r); ld_data = row_val(r, 0); ld_last = (r == D - 1);
            sample();
            check("t1_no_grant", req_grant, 0);
            check("t1_run_low", run, 0);
            step();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sample();
            if (c == 0) check("t1_run_high", run, 1);
            check("t1_rr_order", req_grant, exp_t1[c]);
            step();
        end

        // T2: engines 1 and 3 alternate; pointer is at 1 after T1
        req_valid = 4'b1010;
        set_addr(1, 4, 9);
        set_addr(3, 17, 0);
        for (int c = 0; c < 6; c++) begin
            sample();
            check("t2_grant", req_grant, (c % 2 == 0) ? 4'b0010 : 4'b1000);
            if (c > 0) begin
                check("t2_resp_valid", resp_valid, (c % 2 == 1) ? 4'b0010 : 4'b1000);
                check_row("t2_data0", resp_data0, (c % 2 == 1) ? row_val(4, 0) : row_val(17, 0));
                check_row("t2_data1", resp_data1, (c % 2 == 1) ? row_val(9, 0) : row_val(0, 0));
            end
            step();
        end
        req_valid = '0;
        sample();
        check("t2_last_resp", resp_valid, 4'b1000);
        check_row("t2_last_data0", resp_data0, row_val(17, 0));

        // T3: write to row 5 blocks the read of row 5 in the same cycle
        step();
        ld_valid = 1'b1; ld_addr = 5'd5; ld_data = row_val(5, 1);
        req_valid = 4'b0100;
        set_addr(2, 5, 6);
        sample();
        check("t3_blocked", req_grant, 0);
        check("t3_wEn", sram_wEn, 1);
        step();
        ld_valid = 1'b0;
        sample();
        check("t3_grant", req_grant, 4'b0100);
        step();
        req_valid = '0;
        sample();
        check("t3_resp_valid", resp_valid, 4'b0100);
        check_row("t3_new_row5", resp_data0, row_val(5, 1));
        check_row("t3_row6", resp_data1, row_val(6, 0));

        // T4: out-of-range read and write
        step();
        req_valid = 4'b0001;
        set_addr(0, 3, 20);
        sample();
        check("t4_grant", req_grant, 4'b0001);
        check("t4_rEn", sram_rEn, 0);
        step();
        req_valid = '0;
        ld_valid = 1'b1; ld_addr = 5'd25; ld_data = row_val(25, 2);
        sample();
        check("t4_resp_valid", resp_valid, 4'b0001);
        check("t4_resp_err", resp_err, 1);
        check("t4_wEn", sram_wEn, 0);
        step();
        ld_valid = 1'b0;
        sample();
        check("t4_ld_err", ld_err, 1);
        step();
        sample();
        check("t4_ld_err_clear", ld_err, 0);

        // T5: reset right after a grant to engine 2 discards the response
        step();
        req_valid = 4'b0100;
        set_addr(2, 5, 6);
        sample();
        check("t5_grant", req_grant, 4'b0100);
        step();
        rst = 1'b1;
        req_valid = '0;
        sample();
        check("t5_no_resp", resp_valid, 0);
        check("t5_no_grant", req_grant, 0);
        step();
        rst = 1'b0;
        sample();
        check("t5_post_resp", resp_valid, 0);
        check("t5_init", run, 0);
        step();
        req_valid = 4'b1010;
        ld_valid = 1'b1; ld_last = 1'b1; ld_addr = 5'd0; ld_data = row_val(0, 3);
        sample();
        check("t5_init_no_grant", req_grant, 0);
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
        sample();
        check("t5_run", run, 1);
        check("t5_lowest_first", req_grant, 4'b0010);
        step();
        req_valid = '0;
        sample();
        check("t5_resp", resp_valid, 4'b0010);
        check_row("t5_data0", resp_data0, row_val(4, 0));
        check_row("t5_data1", resp_data1, row_val(9, 0));
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
